// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: ALU control encodings and the bubble control word.
package mips_pkg;

   localparam int ALUC_W = 3;

   localparam logic [ALUC_W-1:0] ALU_AND = 3'b000;
   localparam logic [ALUC_W-1:0] ALU_OR  = 3'b001;
   localparam logic [ALUC_W-1:0] ALU_ADD = 3'b010;
   localparam logic [ALUC_W-1:0] ALU_SUB = 3'b110;
   localparam logic [ALUC_W-1:0] ALU_SLT = 3'b111;

   // Order: {reg_wr_en, mem_to_reg_wr, mem_wr_en, alu_src}
   localparam logic [3:0] CTRL_NOP = 4'b0000;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: holds at all-ones, clears only on synchronous reset.
module sat_counter #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   output logic [CNT_W-1:0] count
);

   always_ff @(posedge clk) begin
      if (rst)
         count <= '0;
      else if (inc && (count != {CNT_W{1'b1}}))
         count <= count + 1'b1;
   end

endmodule

// File: rtl/id_ex_pipe_reg.sv
// ID->EX pipeline register with RegDst resolution, bubble insertion and
// saturating bubble/issue performance counters.
module id_ex_pipe_reg #(
   parameter int WIDTH  = 32,
   parameter int ADDR_W = 5,
   parameter int ALUC_W = 3,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stall,
   input  logic              flush,
   input  logic              id_reg_wr_en,
   input  logic              id_mem_to_reg_wr,
   input  logic              id_mem_wr_en,
   input  logic              id_alu_src,
   input  logic              id_reg_dst,
   input  logic [ALUC_W-1:0] id_alu_ctrl,
   input  logic [WIDTH-1:0]  id_rd1,
   input  logic [WIDTH-1:0]  id_rd2,
   input  logic [ADDR_W-1:0] id_rs,
   input  logic [ADDR_W-1:0] id_rt,
   input  logic [ADDR_W-1:0] id_rd,
   input  logic [WIDTH-1:0]  id_sign_imm,
   output logic              ex_reg_wr_en,
   output logic              ex_mem_to_reg_wr,
   output logic              ex_mem_wr_en,
   output logic              ex_alu_src,
   output logic [ALUC_W-1:0] ex_alu_ctrl,
   output logic [WIDTH-1:0]  ex_rd1,
   output logic [WIDTH-1:0]  ex_rd2,
   output logic [ADDR_W-1:0] ex_rs,
   output logic [ADDR_W-1:0] ex_rt,
   output logic [WIDTH-1:0]  ex_sign_imm,
   output logic [ADDR_W-1:0] ex_reg_wr_addr,
   output logic              ex_valid,
   output logic [CNT_W-1:0]  bubble_cnt,
   output logic [CNT_W-1:0]  issue_cnt
);
   import mips_pkg::*;

   logic bubble_inc;
   logic issue_inc;

   assign bubble_inc = !rst && flush;
   assign issue_inc  = !rst && !flush && !stall;

   always_ff @(posedge clk) begin
      if (rst) begin
         {ex_reg_wr_en, ex_mem_to_reg_wr, ex_mem_wr_en, ex_alu_src} <= CTRL_NOP;
         ex_alu_ctrl    <= '0;
         ex_rd1         <= '0;
         ex_rd2         <= '0;
         ex_rs          <= '0;
         ex_rt          <= '0;
         ex_sign_imm    <= '0;
         ex_reg_wr_addr <= '0;
         ex_valid       <= 1'b0;
      end else if (flush) begin
         // Zeroed rs/rt keep the hazard unit from forwarding to or stalling on a bubble.
         {ex_reg_wr_en, ex_mem_to_reg_wr, ex_mem_wr_en, ex_alu_src} <= CTRL_NOP;
         ex_alu_ctrl    <= '0;
         ex_rd1         <= '0;
         ex_rd2         <= '0;
         ex_rs          <= '0;
         ex_rt          <= '0;
         ex_sign_imm    <= '0;
         ex_reg_wr_addr <= '0;
         ex_valid       <= 1'b0;
      end else if (!stall) begin
         ex_reg_wr_en     <= id_reg_wr_en;
         ex_mem_to_reg_wr <= id_mem_to_reg_wr;
         ex_mem_wr_en     <= id_mem_wr_en;
         ex_alu_src       <= id_alu_src;
         ex_alu_ctrl      <= id_alu_ctrl;
         ex_rd1           <= id_rd1;
         ex_rd2           <= id_rd2;
         ex_rs            <= id_rs;
         ex_rt            <= id_rt;
         ex_sign_imm      <= id_sign_imm;
         // Address is loaded even when reg_wr_en=0; consumers gate it with ex_reg_wr_en.
         ex_reg_wr_addr   <= id_reg_dst ? id_rd : id_rt;
         ex_valid         <= 1'b1;
      end
   end

   sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (bubble_inc),
      .count (bubble_cnt)
   );

   sat_counter #(.CNT_W(CNT_W)) u_issue_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (issue_inc),
      .count (issue_cnt)
   );

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Bench for id_ex_pipe_reg: table-driven vectors with a queue scoreboard fed by a
// reference model; a second instance with 4-bit counters exercises saturation.
module tb_id_ex_pipe_reg;
   import mips_pkg::*;

   logic        clk = 1'b0;
   logic        rst, stall, flush;
   logic        id_reg_wr_en, id_mem_to_reg_wr, id_mem_wr_en, id_alu_src, id_reg_dst;
   logic [2:0]  id_alu_ctrl;
   logic [31:0] id_rd1, id_rd2, id_sign_imm;
   logic [4:0]  id_rs, id_rt, id_rd;

   logic        ex_reg_wr_en, ex_mem_to_reg_wr, ex_mem_wr_en, ex_alu_src, ex_valid;
   logic [2:0]  ex_alu_ctrl;
   logic [31:0] ex_rd1, ex_rd2, ex_sign_imm;
   logic [4:0]  ex_rs, ex_rt, ex_reg_wr_addr;
   logic [15:0] bubble_cnt, issue_cnt;

   logic        s_reg_wr_en, s_mem_to_reg_wr, s_mem_wr_en, s_alu_src, s_valid;
   logic [2:0]  s_alu_ctrl;
   logic [31:0] s_rd1, s_rd2, s_sign_imm;
   logic [4:0]  s_rs, s_rt, s_reg_wr_addr;
   logic [3:0]  s_bubble_cnt, s_issue_cnt;

   always #5 clk = ~clk;

   id_ex_pipe_reg dut (
      .clk(clk), .rst(rst), .stall(stall), .flush(flush),
      .id_reg_wr_en(id_reg_wr_en), .id_mem_to_reg_wr(id_mem_to_reg_wr),
      .id_mem_wr_en(id_mem_wr_en), .id_alu_src(id_alu_src), .id_reg_dst(id_reg_dst),
      .id_alu_ctrl(id_alu_ctrl), .id_rd1(id_rd1), .id_rd2(id_rd2),
      .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_sign_imm(id_sign_imm),
      .ex_reg_wr_en(ex_reg_wr_en), .ex_mem_to_reg_wr(ex_mem_to_reg_wr),
      .ex_mem_wr_en(ex_mem_wr_en), .ex_alu_src(ex_alu_src), .ex_alu_ctrl(ex_alu_ctrl),
      .ex_rd1(ex_rd1), .ex_rd2(ex_rd2), .ex_rs(ex_rs), .ex_rt(ex_rt),
      .ex_sign_imm(ex_sign_imm), .ex_reg_wr_addr(ex_reg_wr_addr), .ex_valid(ex_valid),
      .bubble_cnt(bubble_cnt), .issue_cnt(issue_cnt)
   );

   id_ex_pipe_reg #(.CNT_W(4)) dut_small (
      .clk(clk), .rst(rst), .stall(stall), .flush(flush),
      .id_reg_wr_en(id_reg_wr_en), .id_mem_to_reg_wr(id_mem_to_reg_wr),
      .id_mem_wr_en(id_mem_wr_en), .id_alu_src(id_alu_src), .id_reg_dst(id_reg_dst),
      .id_alu_ctrl(id_alu_ctrl), .id_rd1(id_rd1), .id_rd2(id_rd2),
      .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_sign_imm(id_sign_imm),
      .ex_reg_wr_en(s_reg_wr_en), .ex_mem_to_reg_wr(s_mem_to_reg_wr),
      .ex_mem_wr_en(s_mem_wr_en), .ex_alu_src(s_alu_src), .ex_alu_ctrl(s_alu_ctrl),
      .ex_rd1(s_rd1), .ex_rd2(s_rd2), .ex_rs(s_rs), .ex_rt(s_rt),
      .ex_sign_imm(s_sign_imm), .ex_reg_wr_addr(s_reg_wr_addr), .ex_valid(s_valid),
      .bubble_cnt(s_bubble_cnt), .issue_cnt(s_issue_cnt)
   );

   typedef struct packed {
      logic        rst, flush, stall, rdst, wr_en, m2r, mwr, asrc;
      logic [2:0]  aluc;
      logic [4:0]  rs, rt, rd;
      logic [31:0] rd1, rd2, imm;
      logic        e_valid;
      logic [4:0]  e_wr;
      logic [15:0] e_bub, e_iss;
   } vec_t;

   typedef struct packed {
      logic        wr_en, m2r, mwr, asrc;
      logic [2:0]  aluc;
      logic [31:0] rd1, rd2;
      logic [4:0]  rs, rt;
      logic [31:0] imm;
      logic [4:0]  wr;
      logic        valid;
      logic [15:0] bub, iss;
      logic [3:0]  bub_s, iss_s;
   } out_t;

   out_t  m;
   out_t  sb_q[$];
   vec_t  tbl[14];
   int    errors = 0;
   int    checks = 0;

   function automatic vec_t mk(
      input logic r, f, s, rdst, we, m2r, mwr, asrc, input logic [2:0] aluc,
      input logic [4:0] rs, rt, rd, input logic [31:0] rd1, rd2, imm,
      input logic ev, input logic [4:0] ewr, input logic [15:0] ebub, eiss);
      vec_t v;
      v.rst = r; v.flush = f; v.stall = s; v.rdst = rdst; v.wr_en = we;
      v.m2r = m2r; v.mwr = mwr; v.asrc = asrc; v.aluc = aluc;
      v.rs = rs; v.rt = rt; v.rd = rd; v.rd1 = rd1; v.rd2 = rd2; v.imm = imm;
      v.e_valid = ev; v.e_wr = ewr; v.e_bub = ebub; v.e_iss = eiss;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model of one clock edge, following rst > flush > stall > load.
   task automatic model_step(input vec_t v);
      if (v.rst) begin
         m = '0;
      end else if (v.flush) begin
         m.wr_en = 0; m.m2r = 0; m.mwr = 0; m.asrc = 0; m.aluc = '0;
         m.rd1 = '0; m.rd2 = '0; m.rs = '0; m.rt = '0; m.imm = '0; m.wr = '0;
         m.valid = 0;
         if (m.bub != 16'hFFFF) m.bub = m.bub + 16'd1;
         if (m.bub_s != 4'hF) m.bub_s = m.bub_s + 4'd1;
      end else if (!v.stall) begin
         m.wr_en = v.wr_en; m.m2r = v.m2r; m.mwr = v.mwr; m.asrc = v.asrc;
         m.aluc = v.aluc; m.rd1 = v.rd1; m.rd2 = v.rd2; m.rs = v.rs; m.rt = v.rt;
         m.imm = v.imm; m.wr = v.rdst ? v.rd : v.rt; m.valid = 1;
         if (m.iss != 16'hFFFF) m.iss = m.iss + 16'd1;
         if (m.iss_s != 4'hF) m.iss_s = m.iss_s + 4'd1;
      end
   endtask

   task automatic apply(input vec_t v, input bit use_tbl);
      out_t e;
      rst = v.rst; flush = v.flush; stall = v.stall; id_reg_dst = v.rdst;
      id_reg_wr_en = v.wr_en; id_mem_to_reg_wr = v.m2r; id_mem_wr_en = v.mwr;
      id_alu_src = v.asrc; id_alu_ctrl = v.aluc; id_rs = v.rs; id_rt = v.rt;
      id_rd = v.rd; id_rd1 = v.rd1; id_rd2 = v.rd2; id_sign_imm = v.imm;
      model_step(v);
      sb_q.push_back(m);
      @(posedge clk);
      #1;
      e = sb_q.pop_front();
      chk("reg_wr_en", ex_reg_wr_en, e.wr_en);
      chk("mem_to_reg", ex_mem_to_reg_wr, e.m2r);
      chk("mem_wr_en", ex_mem_wr_en, e.mwr);
      chk("alu_src", ex_alu_src, e.asrc);
      chk("alu_ctrl", ex_alu_ctrl, e.aluc);
      chk("rd1", ex_rd1, e.rd1);
      chk("rd2", ex_rd2, e.rd2);
      chk("rs", ex_rs, e.rs);
      chk("rt", ex_rt, e.rt);
      chk("imm", ex_sign_imm, e.imm);
      chk("wr_addr", ex_reg_wr_addr, e.wr);
      chk("valid", ex_valid, e.valid);
      chk("bubble_cnt", bubble_cnt, e.bub);
      chk("issue_cnt", issue_cnt, e.iss);
      chk("small_valid", s_valid, e.valid);
      chk("small_bubble_cnt", s_bubble_cnt, e.bub_s);
      chk("small_issue_cnt", s_issue_cnt, e.iss_s);
      if (use_tbl) begin
         chk("tbl_valid", ex_valid, v.e_valid);
         chk("tbl_wr_addr", ex_reg_wr_addr, v.e_wr);
         chk("tbl_bubble", bubble_cnt, v.e_bub);
         chk("tbl_issue", issue_cnt, v.e_iss);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t fl;
      m = '0;
      //            r f s rd we m2 mw as alu      rs     rt     rd     rd1           rd2           imm           ev ewr    bub     iss
      tbl[0]  = mk(1,0,0, 1, 1, 1, 1, 1, ALU_SUB, 5'd7,  5'd8,  5'd9,  32'hDEAD,     32'hBEEF,     32'h1234,     0, 5'd0,  16'd0, 16'd0);
      tbl[1]  = tbl[0];
      tbl[2]  = mk(0,0,0, 1, 1, 0, 0, 0, ALU_ADD, 5'd1,  5'd2,  5'd3,  32'h10,       32'h20,       32'h0,        1, 5'd3,  16'd0, 16'd1);
      tbl[3]  = mk(0,0,0, 0, 1, 1, 0, 1, ALU_ADD, 5'd1,  5'd5,  5'd0,  32'h10,       32'h0,        32'h4,        1, 5'd5,  16'd0, 16'd2);
      tbl[4]  = mk(0,1,0, 1, 1, 0, 0, 0, ALU_SUB, 5'd4,  5'd6,  5'd7,  32'h1,        32'h2,        32'h3,        0, 5'd0,  16'd1, 16'd2);
      tbl[5]  = mk(0,0,0, 1, 1, 0, 0, 0, ALU_OR,  5'd10, 5'd11, 5'd12, 32'hAAAA,     32'h5555,     32'h0,        1, 5'd12, 16'd1, 16'd3);
      tbl[6]  = mk(0,0,1, 0, 0, 1, 1, 1, ALU_AND, 5'd20, 5'd21, 5'd22, 32'h111,      32'h222,      32'h333,      1, 5'd12, 16'd1, 16'd3);
      tbl[7]  = mk(0,0,1, 1, 1, 0, 1, 0, ALU_SLT, 5'd23, 5'd24, 5'd25, 32'h444,      32'h555,      32'hFFFF_FFF0,1, 5'd12, 16'd1, 16'd3);
      tbl[8]  = mk(0,0,1, 0, 0, 1, 0, 1, ALU_SUB, 5'd26, 5'd27, 5'd28, 32'h666,      32'h777,      32'h888,      1, 5'd12, 16'd1, 16'd3);
      tbl[9]  = mk(0,1,1, 1, 1, 0, 0, 0, ALU_ADD, 5'd1,  5'd2,  5'd3,  32'h9,        32'hA,        32'hB,        0, 5'd0,  16'd2, 16'd3);
      tbl[10] = mk(0,0,0, 0, 0, 0, 1, 1, ALU_ADD, 5'd2,  5'd9,  5'd17, 32'h40,       32'h99,       32'h8,        1, 5'd9,  16'd2, 16'd4);
      tbl[11] = mk(0,0,0, 1, 0, 0, 0, 0, ALU_SUB, 5'd21, 5'd22, 5'd20, 32'h5,        32'h5,        32'hFFFF_FFFC,1, 5'd20, 16'd2, 16'd5);
      tbl[12] = mk(1,1,0, 1, 1, 0, 0, 0, ALU_ADD, 5'd1,  5'd2,  5'd3,  32'h77,       32'h88,       32'h99,       0, 5'd0,  16'd0, 16'd0);
      tbl[13] = mk(0,0,0, 1, 1, 0, 0, 0, ALU_SLT, 5'd3,  5'd4,  5'd5,  32'h7,        32'h8,        32'h0,        1, 5'd5,  16'd0, 16'd1);

      for (int i = 0; i < 14; i++) apply(tbl[i], 1'b1);

      // Long flush run: 16-bit counter keeps counting, 4-bit counter pins at 15.
      fl = mk(0,1,0, 1,1,1,1,1, ALU_OR, 5'd9, 5'd10, 5'd11, 32'h1, 32'h2, 32'h3, 0, 5'd0, 16'd0, 16'd0);
      for (int i = 0; i < 20; i++) apply(fl, 1'b0);
      chk("sat_small_bubble", s_bubble_cnt, 32'd15);
      chk("sat_big_bubble", bubble_cnt, 32'd20);
      chk("sat_issue_hold", issue_cnt, 32'd1);

      fl.rst = 1'b1;
      apply(fl, 1'b0);
      chk("rst_after_sat", s_bubble_cnt, 32'd0);

      // Reset asserted mid-stall, then stall keeps the cleared state.
      apply(tbl[2], 1'b0);
      fl = tbl[5]; fl.stall = 1'b1; fl.rst = 1'b1;
      apply(fl, 1'b0);
      fl.rst = 1'b0;
      apply(fl, 1'b0);
      chk("stall_after_rst_valid", ex_valid, 32'd0);
      fl.stall = 1'b0;
      apply(fl, 1'b0);
      chk("load_after_stall_wr", ex_reg_wr_addr, 32'd12);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
